// File: rtl/qsys_led_pkg.sv
// qsys_led_pkg: shared widths, CSR map, grant modes and arbiter state encodings
package qsys_led_pkg;
  localparam int RGB_W = 24;
  localparam int IDX_W = 3;
  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_RR    = 2'd1;
  localparam logic [1:0] MODE_PRIO  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_SEL    = 2'd1;
  localparam logic [1:0] ADDR_DWELL  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_RUN = 2'd1, ST_BLANK = 2'd2} state_e;
endpackage

// File: rtl/qsys_led_rr_pick.sv
// qsys_led_rr_pick: finds the first valid index after cur, wrapping, excluding cur itself
module qsys_led_rr_pick
  import qsys_led_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] cur,
  output logic [IDX_W-1:0] nxt,
  output logic             found
);
  localparam int IW = $clog2(N);
  int idx;
  // Scan downward in distance so the nearest valid successor is the last one written
  always_comb begin
    nxt = cur;
    found = 1'b0;
    idx = 0;
    for (int k = N - 1; k >= 1; k--) begin
      idx = int'(cur) + k;
      idx = idx >= N ? idx - N : idx;
      if (valid[idx[IW-1:0]]) begin
        nxt = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/qsys_led_stream_arbiter.sv
// qsys_led_stream_arbiter: shares one RGB Avalon-ST LED sink between N_SRC sources; LED_ARB_BLANK_EN adds a dark beat per grant change
module qsys_led_stream_arbiter
  import qsys_led_pkg::*;
#(
  parameter int                 N_SRC     = 4,
  parameter int                 DWELL_W   = 24,
  parameter logic [DWELL_W-1:0] DWELL_RST = 24'hFFFFFF
) (
  input  logic                   csi_MCLK_clk,
  input  logic                   rsi_MRST_reset,
  input  logic [RGB_W*N_SRC-1:0] asi_SRC_data,
  input  logic [N_SRC-1:0]       asi_SRC_valid,
  output logic [N_SRC-1:0]       asi_SRC_ready,
  output logic [RGB_W-1:0]       aso_LEDS_data,
  output logic                   aso_LEDS_valid,
  input  logic                   aso_LEDS_ready,
  input  logic [1:0]             avs_CTRL_address,
  input  logic                   avs_CTRL_write,
  input  logic [31:0]            avs_CTRL_writedata,
  input  logic                   avs_CTRL_read,
  output logic [31:0]            avs_CTRL_readdata
);
`ifdef LED_ARB_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  state_e             state_q, state_d;
  logic [2:0]         ctrl_q, ctrl_d, sel_q, sel_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic [IDX_W-1:0]   grant_q, grant_d, prio_idx, rr_nxt, sel_cl;
  logic [RGB_W-1:0]   data_q, data_d, src_data_g;
  logic               valid_q, valid_d, prio_found, rr_found, load, src_valid_g, rr_switch, en;
  logic [1:0]         mode;
  logic [N_SRC-1:0]   gnt_oh;
  logic [31:0]        rdata_q, rdata_d;

  assign mode = ctrl_q[1:0];
  assign en = ctrl_q[2];
  assign load = !valid_q || aso_LEDS_ready;
  assign gnt_oh = N_SRC'(1) << grant_q;
  assign src_valid_g = |(asi_SRC_valid & gnt_oh);
  assign sel_cl = ({1'b0, sel_q} < 4'(N_SRC)) ? sel_q : '0;
  assign rr_switch = (cnt_q == dwell_q) || !src_valid_g;
  assign asi_SRC_ready = (state_q == ST_RUN && load) ? gnt_oh : '0;
  assign aso_LEDS_data = data_q;
  assign aso_LEDS_valid = valid_q;
  assign avs_CTRL_readdata = rdata_q;

  qsys_led_rr_pick #(.N(N_SRC)) u_rr (
    .valid(asi_SRC_valid),
    .cur  (grant_q),
    .nxt  (rr_nxt),
    .found(rr_found)
  );

  // Granted source's beat plus the lowest-index valid source for priority mode
  always_comb begin
    src_data_g = '0;
    prio_idx = '0;
    prio_found = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (grant_q == IDX_W'(i)) src_data_g = asi_SRC_data[RGB_W*i +: RGB_W];
      if (asi_SRC_valid[i]) begin
        prio_idx = IDX_W'(i);
        prio_found = 1'b1;
      end
    end
  end

  // CSR writes land next cycle; reads are registered for latency 1
  always_comb begin
    ctrl_d = (avs_CTRL_write && avs_CTRL_address == ADDR_CTRL) ? avs_CTRL_writedata[2:0] : ctrl_q;
    sel_d = (avs_CTRL_write && avs_CTRL_address == ADDR_SEL) ? avs_CTRL_writedata[2:0] : sel_q;
    dwell_d = (avs_CTRL_write && avs_CTRL_address == ADDR_DWELL) ? avs_CTRL_writedata[DWELL_W-1:0] : dwell_q;
    rdata_d = !avs_CTRL_read ? rdata_q :
              avs_CTRL_address == ADDR_CTRL ? {29'd0, ctrl_q} :
              avs_CTRL_address == ADDR_SEL ? {29'd0, sel_q} :
              avs_CTRL_address == ADDR_DWELL ? 32'(dwell_q) :
              {23'd0, valid_q, 5'd0, grant_q};
  end

  // Grant selection; blank beats freeze the grant, round-robin only advances while running
  always_comb begin
    cnt_d = (state_q == ST_RUN && mode == MODE_RR && !rr_switch) ? cnt_q + 1'b1 : '0;
    grant_d = state_q == ST_BLANK ? grant_q :
              mode == MODE_PRIO ? (prio_found ? prio_idx : grant_q) :
              mode == MODE_RR ? ((state_q == ST_RUN && rr_switch && rr_found) ? rr_nxt : grant_q) :
              sel_cl;
  end

  // Next state: enable gates everything, a grant change detours through one blank beat when built in
  always_comb begin
    state_d = !en ? ST_OFF :
              state_q == ST_OFF ? ST_RUN :
              state_q == ST_BLANK ? (load ? ST_RUN : ST_BLANK) :
              (BLANK_EN && grant_d != grant_q) ? ST_BLANK : ST_RUN;
  end

  // Output register: dark when off, zero beat when blanking, granted beat when running
  always_comb begin
    data_d = data_q;
    valid_d = valid_q;
    if (state_q == ST_OFF) begin
      data_d = '0;
      valid_d = 1'b1;
    end else if (load) begin
      data_d = state_q == ST_BLANK ? '0 : src_data_g;
      valid_d = state_q == ST_BLANK || src_valid_g;
    end
  end

  // State register
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) state_q <= ST_OFF;
    else state_q <= state_d;
  end

  // CSR, grant, dwell counter and output registers
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      ctrl_q <= '0;
      sel_q <= '0;
      dwell_q <= DWELL_RST;
      rdata_q <= '0;
      grant_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b1;
    end else begin
      ctrl_q <= ctrl_d;
      sel_q <= sel_d;
      dwell_q <= dwell_d;
      rdata_q <= rdata_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_qsys_led_stream_arbiter.sv
// tb_qsys_led_stream_arbiter: directed checks of reset, CSR, fixed/RR/priority grants, backpressure, blanking and async reset
module tb_qsys_led_stream_arbiter;
  import qsys_led_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [95:0] src_data;
  logic [3:0]  src_valid, src_ready;
  logic [23:0] leds_data;
  logic        leds_valid, leds_ready;
  logic [1:0]  addr;
  logic        wr, rd;
  logic [31:0] wdata, rdata, r;
  int          n_chk = 0;
  int          n_fail = 0;
  int          seq[8] = '{0, 1, 2, 3, 0, 2, 3, 0};

  always #5 clk = ~clk;

  qsys_led_stream_arbiter dut (
    .csi_MCLK_clk      (clk),
    .rsi_MRST_reset    (rst),
    .asi_SRC_data      (src_data),
    .asi_SRC_valid     (src_valid),
    .asi_SRC_ready     (src_ready),
    .aso_LEDS_data     (leds_data),
    .aso_LEDS_valid    (leds_valid),
    .aso_LEDS_ready    (leds_ready),
    .avs_CTRL_address  (addr),
    .avs_CTRL_write    (wr),
    .avs_CTRL_writedata(wdata),
    .avs_CTRL_read     (rd),
    .avs_CTRL_readdata (rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic set_src(input int i, input logic [23:0] v);
    src_data[24*i +: 24] = v;
  endtask

  initial begin
    src_data = '0;
    src_valid = '0;
    leds_ready = 1'b1;
    addr = '0;
    wr = 1'b0;
    rd = 1'b0;
    wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_data", leds_data, 0);
    chk("rst_valid", leds_valid, 1);
    chk("rst_ready", src_ready, 0);
    csr_rd(ADDR_STATUS, r);
    chk("rst_status", r, 32'h100);
    csr_rd(ADDR_DWELL, r);
    chk("rst_dwell", r, 32'hFFFFFF);

    set_src(2, 24'h00FF00);
    src_valid = 4'b0100;
    csr_wr(ADDR_SEL, 2);
    csr_wr(ADDR_CTRL, 32'h4);
    chk("fix_off_ready", src_ready, 0);
    tick();
    chk("fix_ready", src_ready, 4'b0100);
    chk("fix_data_pre", leds_data, 0);
    tick();
    chk("fix_data", leds_data, 24'h00FF00);
    chk("fix_valid", leds_valid, 1);
    csr_rd(ADDR_STATUS, r);
    chk("fix_status", r, 32'h102);

    for (int i = 0; i < 4; i++) set_src(i, 24'h111111 * (i + 1));
    src_valid = 4'b1111;
    csr_wr(ADDR_SEL, 0);
    csr_wr(ADDR_DWELL, 3);
    csr_wr(ADDR_CTRL, 32'h5);
    for (int k = 0; k <= 28; k++) begin
      chk($sformatf("rr_ready_%0d", k), src_ready, 32'(4'b0001 << seq[k/4]));
      if (k == 5) chk("rr_data_src1", leds_data, 24'h222222);
      if (k == 21) chk("rr_data_src2", leds_data, 24'h333333);
      if (k == 16) src_valid = 4'b1101;
      tick();
    end

    src_valid = 4'b1000;
    csr_wr(ADDR_CTRL, 32'h6);
    tick();
    chk("prio_src3", src_ready, 4'b1000);
    src_valid = 4'b1010;
    #1;
    chk("prio_hold", src_ready, 4'b1000);
    tick();
    chk("prio_src1", src_ready, 4'b0010);
    src_valid = 4'b1000;
    #1;
    tick();
    chk("prio_back3", src_ready, 4'b1000);
    chk("prio_gap_valid", leds_valid, 0);
    tick();
    chk("prio_data3", leds_data, 24'h444444);
    chk("prio_valid3", leds_valid, 1);

    set_src(0, 24'hA00001);
    src_valid = 4'b0001;
    csr_wr(ADDR_SEL, 0);
    csr_wr(ADDR_CTRL, 32'h4);
    tick();
    tick();
    chk("bp_first", leds_data, 24'hA00001);
    leds_ready = 1'b0;
    set_src(0, 24'hA00002);
    #1;
    chk("bp_ready0", src_ready, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("bp_hold_%0d", k), {src_ready, leds_valid, leds_data}, {4'b0000, 1'b1, 24'hA00001});
    end
    leds_ready = 1'b1;
    #1;
    chk("bp_release", src_ready, 4'b0001);
    tick();
    src_valid = 4'b0000;
    chk("bp_next", leds_data, 24'hA00002);
    chk("bp_next_valid", leds_valid, 1);
    tick();
    chk("bp_no_dup", leds_valid, 0);

    set_src(0, 24'h0000AA);
    set_src(1, 24'h00BB00);
    src_valid = 4'b0011;
    tick();
    tick();
    csr_wr(ADDR_SEL, 1);
    chk("sw_old", leds_data, 24'h0000AA);
    tick();
    chk("sw_old2", leds_data, 24'h0000AA);
`ifdef LED_ARB_BLANK_EN
    chk("blank_ready", src_ready, 0);
    tick();
    chk("blank_beat", {leds_valid, leds_data}, {1'b1, 24'h000000});
    tick();
    chk("blank_new", leds_data, 24'h00BB00);
`else
    chk("sw_ready", src_ready, 4'b0010);
    tick();
    chk("sw_new", leds_data, 24'h00BB00);
`endif

    src_valid = 4'b1111;
    csr_wr(ADDR_DWELL, 0);
    csr_wr(ADDR_CTRL, 32'h5);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data", leds_data, 0);
    chk("arst_valid", leds_valid, 1);
    chk("arst_ready", src_ready, 0);
    #3;
    rst = 1'b0;
    tick();
    chk("arst_off_ready", src_ready, 0);
    csr_rd(ADDR_STATUS, r);
    chk("arst_status", r, 32'h100);
    csr_rd(ADDR_CTRL, r);
    chk("arst_ctrl", r, 0);
    csr_rd(ADDR_DWELL, r);
    chk("arst_dwell", r, 32'hFFFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
